// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_pkg
// Purpose : Sequencer state encoding and width helpers shared by the SNN
//           inference sequencer and its spike counter bank.
// Rev     : 1.0  initial release
// ============================================================================
package snn_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      REDUCE = 3'd4,
      DONE   = 3'd5
   } seq_state_e;

   // Index/counter width that never collapses to zero bits for tiny ranges.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

   localparam int c_default_neurons = 4;
   localparam int c_default_addr_w  = clog2_min1(c_default_neurons * c_default_neurons);
   localparam int c_default_class_w = clog2_min1(c_default_neurons);

endpackage
`default_nettype wire

// File: rtl/snn_spike_counter_bank.sv
`default_nettype none
// ============================================================================
// Module  : snn_spike_counter_bank
// Purpose : One saturating spike counter per output neuron, synchronous clear,
//           shared increment enable and an indexed read port for the argmax.
// Rev     : 1.0  initial release
// ============================================================================
module snn_spike_counter_bank
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = c_default_neurons,
   parameter int CNT_W       = 5,
   parameter int IDX_W       = c_default_class_w
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [NUM_NEURONS-1:0] spikes,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [CNT_W-1:0]       rd_count
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt [NUM_NEURONS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (enable) begin
         // Hold at full scale so a very active neuron can never wrap to a small count.
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (spikes[i] && (r_cnt[i] != c_cnt_max)) begin
               r_cnt[i] <= r_cnt[i] + c_cnt_one;
            end
         end
      end
   end

   assign rd_count = r_cnt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/snn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : snn_inference_sequencer
// Purpose : Loads synapse weights into the LIF network, streams spike frames,
//           counts output spikes per neuron and reduces them to a winning class.
// Rev     : 1.0  initial release
// ============================================================================
module snn_inference_sequencer
   import snn_pkg::*;
#(
   parameter int NEURONS_PER_LAYER = 4,
   parameter int SYNAPSE_WIDTH     = 8,
   parameter int NUM_TIMESTEPS     = 16,
   parameter int DRAIN_CYCLES      = 2,
   localparam int CNT_W  = $clog2(NUM_TIMESTEPS + DRAIN_CYCLES + 1),
   localparam int ADDR_W = clog2_min1(NEURONS_PER_LAYER * NEURONS_PER_LAYER),
   localparam int CLS_W  = clog2_min1(NEURONS_PER_LAYER)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            load_weights,
   input  logic                            abort,
   input  logic                            w_valid,
   output logic                            w_ready,
   input  logic signed [SYNAPSE_WIDTH-1:0] w_data,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [NEURONS_PER_LAYER-1:0]    s_spikes,
   output logic [NEURONS_PER_LAYER-1:0]    net_input_spikes,
   input  logic [NEURONS_PER_LAYER-1:0]    net_output_spikes,
   output logic                            synapse_prog_en,
   output logic [ADDR_W-1:0]               synapse_addr,
   output logic signed [SYNAPSE_WIDTH-1:0] synapse_data,
   output logic                            busy,
   output logic                            done,
   output logic [CLS_W-1:0]                result_class,
   output logic [CNT_W-1:0]                result_count
);

   localparam int c_ts_w    = clog2_min1(NUM_TIMESTEPS);
   localparam int c_drain_w = clog2_min1(DRAIN_CYCLES);

   localparam logic [ADDR_W-1:0]    c_addr_last  = ADDR_W'(NEURONS_PER_LAYER * NEURONS_PER_LAYER - 1);
   localparam logic [ADDR_W-1:0]    c_addr_one   = ADDR_W'(1);
   localparam logic [c_ts_w-1:0]    c_ts_last    = c_ts_w'(NUM_TIMESTEPS - 1);
   localparam logic [c_ts_w-1:0]    c_ts_one     = c_ts_w'(1);
   localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);
   localparam logic [CLS_W-1:0]     c_idx_last   = CLS_W'(NEURONS_PER_LAYER - 1);
   localparam logic [CLS_W-1:0]     c_idx_one    = CLS_W'(1);
   localparam seq_state_e           c_after_run  = (DRAIN_CYCLES > 0) ? DRAIN : REDUCE;

   seq_state_e                   r_state;
   logic [ADDR_W-1:0]            r_waddr;
   logic [c_ts_w-1:0]            r_ts;
   logic [c_drain_w-1:0]         r_drain;
   logic [CLS_W-1:0]             r_idx;
   logic [CLS_W-1:0]             r_best_cls;
   logic [CNT_W-1:0]             r_best_cnt;
   logic [CLS_W-1:0]             r_result_class;
   logic [CNT_W-1:0]             r_result_count;
   logic                         r_prog_en;
   logic [ADDR_W-1:0]            r_syn_addr;
   logic [SYNAPSE_WIDTH-1:0]     r_syn_data;
   logic [NEURONS_PER_LAYER-1:0] r_net_in;
   logic                         r_done;

   logic                         w_w_fire;
   logic                         w_s_fire;
   logic                         w_cnt_clear;
   logic                         w_cnt_en;
   logic [CNT_W-1:0]             w_rd_count;
   logic                         w_take;
   logic [CLS_W-1:0]             w_next_cls;
   logic [CNT_W-1:0]             w_next_cnt;

   // Ready is withheld during abort so nothing is consumed on the cycle we leave.
   assign w_ready     = (r_state == LOAD) && !abort;
   assign s_ready     = (r_state == RUN)  && !abort;
   assign w_w_fire    = w_valid && w_ready;
   assign w_s_fire    = s_valid && s_ready;
   assign w_cnt_clear = (r_state == IDLE) && start && !abort;
   assign w_cnt_en    = (r_state == RUN) || (r_state == DRAIN);

   // Strict greater-than keeps the lowest index on ties.
   assign w_take     = (w_rd_count > r_best_cnt);
   assign w_next_cls = w_take ? r_idx : r_best_cls;
   assign w_next_cnt = w_take ? w_rd_count : r_best_cnt;

   snn_spike_counter_bank #(
      .NUM_NEURONS (NEURONS_PER_LAYER),
      .CNT_W       (CNT_W),
      .IDX_W       (CLS_W)
   ) u_counters (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_cnt_clear),
      .enable   (w_cnt_en),
      .spikes   (net_output_spikes),
      .rd_idx   (r_idx),
      .rd_count (w_rd_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_waddr        <= '0;
         r_ts           <= '0;
         r_drain        <= '0;
         r_idx          <= '0;
         r_best_cls     <= '0;
         r_best_cnt     <= '0;
         r_result_class <= '0;
         r_result_count <= '0;
         r_prog_en      <= 1'b0;
         r_syn_addr     <= '0;
         r_syn_data     <= '0;
         r_net_in       <= '0;
         r_done         <= 1'b0;
      end else begin
         r_prog_en <= w_w_fire;
         r_net_in  <= w_s_fire ? s_spikes : '0;
         r_done    <= 1'b0;
         if (w_w_fire) begin
            r_syn_addr <= r_waddr;
            r_syn_data <= w_data;
         end

         if (abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_ts    <= '0;
                     r_waddr <= '0;
                     r_state <= load_weights ? LOAD : RUN;
                  end
               end
               LOAD: begin
                  if (w_w_fire) begin
                     r_waddr <= r_waddr + c_addr_one;
                     if (r_waddr == c_addr_last) begin
                        r_state <= RUN;
                     end
                  end
               end
               RUN: begin
                  if (w_s_fire) begin
                     r_ts <= r_ts + c_ts_one;
                     if (r_ts == c_ts_last) begin
                        r_drain    <= '0;
                        r_idx      <= '0;
                        r_best_cls <= '0;
                        r_best_cnt <= '0;
                        r_state    <= c_after_run;
                     end
                  end
               end
               DRAIN: begin
                  if (r_drain == c_drain_last) begin
                     r_idx      <= '0;
                     r_best_cls <= '0;
                     r_best_cnt <= '0;
                     r_state    <= REDUCE;
                  end else begin
                     r_drain <= r_drain + c_drain_one;
                  end
               end
               REDUCE: begin
                  r_idx      <= r_idx + c_idx_one;
                  r_best_cls <= w_next_cls;
                  r_best_cnt <= w_next_cnt;
                  if (r_idx == c_idx_last) begin
                     r_result_class <= w_next_cls;
                     r_result_count <= w_next_cnt;
                     r_done         <= 1'b1;
                     r_state        <= DONE;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy             = (r_state != IDLE);
   assign done             = r_done;
   assign synapse_prog_en  = r_prog_en;
   assign synapse_addr     = r_syn_addr;
   assign synapse_data     = r_syn_data;
   assign net_input_spikes = r_net_in;
   assign result_class     = r_result_class;
   assign result_count     = r_result_count;

   a_single_stream: assert property (@(posedge clk) disable iff (!rst_n) !(w_ready && s_ready));

endmodule
`default_nettype wire

// File: tb/tb_snn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_snn_inference_sequencer
// Purpose : Directed scoreboard bench for the SNN inference sequencer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_snn_inference_sequencer;

   localparam int N  = 4;
   localparam int SW = 8;
   localparam int NT = 16;
   localparam int DC = 2;
   localparam int c_done_lat = DC + N + 1;

   typedef struct {int addr; int data; int due;} wr_t;
   typedef struct {int cls; int cnt; int due;} res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          load_weights;
   logic          abort;
   logic          w_valid;
   logic          w_ready;
   logic [SW-1:0] w_data;
   logic          s_valid;
   logic          s_ready;
   logic [N-1:0]  s_spikes;
   logic [N-1:0]  net_input_spikes;
   logic [N-1:0]  net_output_spikes;
   logic          synapse_prog_en;
   logic [3:0]    synapse_addr;
   logic [SW-1:0] synapse_data;
   logic          busy;
   logic          done;
   logic [1:0]    result_class;
   logic [4:0]    result_count;

   int   n_vec = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mdl_addr = 0;
   int   mdl_ts = 0;
   int   n_prog = 0;
   int   n_done = 0;
   int   pend_cls = 0;
   int   pend_cnt = 0;
   logic [N-1:0] exp_in = '0;
   wr_t  wr_q[$];
   res_t res_q[$];

   snn_inference_sequencer #(
      .NEURONS_PER_LAYER (N),
      .SYNAPSE_WIDTH     (SW),
      .NUM_TIMESTEPS     (NT),
      .DRAIN_CYCLES      (DC)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .load_weights      (load_weights),
      .abort             (abort),
      .w_valid           (w_valid),
      .w_ready           (w_ready),
      .w_data            (w_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_spikes          (s_spikes),
      .net_input_spikes  (net_input_spikes),
      .net_output_spikes (net_output_spikes),
      .synapse_prog_en   (synapse_prog_en),
      .synapse_addr      (synapse_addr),
      .synapse_data      (synapse_data),
      .busy              (busy),
      .done              (done),
      .result_class      (result_class),
      .result_count      (result_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: got event/timeout, expected none", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: records handshakes as expectations, pops them when outputs appear.
   task automatic monitor();
      wr_t  we;
      res_t re;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_in = '0;
            mdl_ts = 0;
         end else begin
            check("net_input_spikes", 32'(net_input_spikes), 32'(exp_in));
            if (synapse_prog_en) begin
               n_prog++;
               if (wr_q.size() == 0) flag("unexpected_prog_en");
               else begin
                  we = wr_q.pop_front();
                  check("synapse_addr", 32'(synapse_addr), 32'(we.addr));
                  check("synapse_data", 32'(synapse_data), 32'(we.data));
                  check("prog_latency", 32'(cyc), 32'(we.due));
               end
            end
            if (done) begin
               n_done++;
               if (res_q.size() == 0) flag("unexpected_done");
               else begin
                  re = res_q.pop_front();
                  check("result_class", 32'(result_class), 32'(re.cls));
                  check("result_count", 32'(result_count), 32'(re.cnt));
                  check("done_cycle", 32'(cyc), 32'(re.due));
               end
            end
            exp_in = (s_valid && s_ready) ? s_spikes : '0;
            if (w_valid && w_ready) begin
               wr_q.push_back('{mdl_addr, int'(w_data), cyc + 1});
               mdl_addr++;
            end
            if (s_valid && s_ready) begin
               mdl_ts++;
               if (mdl_ts == NT) res_q.push_back('{pend_cls, pend_cnt, cyc + c_done_lat});
            end
         end
      end
   endtask

   task automatic do_start(input logic lw, input int cls, input int cnt);
      pend_cls     = cls;
      pend_cnt     = cnt;
      mdl_addr     = 0;
      mdl_ts       = 0;
      start        = 1'b1;
      load_weights = lw;
      tick();
      start        = 1'b0;
      load_weights = 1'b0;
   endtask

   task automatic wbeat(input int d);
      bit ok = 0;
      w_valid = 1'b1;
      w_data  = 8'(d);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (w_ready) begin ok = 1; break; end
      end
      if (!ok) flag("w_ready_timeout");
      tick();
      w_valid = 1'b0;
   endtask

   task automatic sframe(input logic [N-1:0] spk, input int gap);
      bit ok = 0;
      repeat (gap) tick();
      s_valid  = 1'b1;
      s_spikes = spk;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      if (!ok) flag("s_ready_timeout");
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) flag("idle_timeout");
      tick();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; load_weights = 1'b0; abort = 1'b0;
      w_valid = 1'b0; w_data = '0; s_valid = 1'b0; s_spikes = '0; net_output_spikes = '0;
      fork monitor(); join_none

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_w_ready", 32'(w_ready), 32'(0));
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_prog_en", 32'(synapse_prog_en), 32'(0));
      check("rst_addr", 32'(synapse_addr), 32'(0));
      check("rst_data", 32'(synapse_data), 32'(0));
      check("rst_net_in", 32'(net_input_spikes), 32'(0));
      check("rst_class", 32'(result_class), 32'(0));
      check("rst_count", 32'(result_count), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      // Weight load 0..15 with a gap before beat 5, then an all-silent run.
      do_start(1'b1, 0, 0);
      check("load_w_ready", 32'(w_ready), 32'(1));
      for (int b = 0; b < 16; b++) begin
         if (b == 5) tick();
         wbeat(b);
      end
      for (int i = 0; i < NT; i++) sframe(4'b0001, 0);
      wait_idle();
      check("prog_pulses_load", 32'(n_prog), 32'(16));

      // Neuron 2 fires on 7 RUN cycles; weight data offered in RUN must be ignored.
      do_start(1'b0, 2, 7);
      check("run_busy", 32'(busy), 32'(1));
      w_valid = 1'b1;
      #1 check("run_w_ready", 32'(w_ready), 32'(0));
      w_valid = 1'b0;
      fork
         begin for (int i = 0; i < NT; i++) sframe(4'b0001, 0); end
         begin repeat (3) tick(); net_output_spikes = 4'b0100; repeat (7) tick(); net_output_spikes = '0; end
      join
      wait_idle();
      repeat (3) tick();
      check("hold_class", 32'(result_class), 32'(2));
      check("hold_count", 32'(result_count), 32'(7));

      // Counts {3,5,5,0}: tie resolves to neuron 1; a start pulse mid-RUN is ignored.
      do_start(1'b0, 1, 5);
      fork
         begin for (int i = 0; i < NT; i++) sframe(4'(i), (i % 4 == 3) ? 1 : 0); end
         begin
            repeat (2) tick(); net_output_spikes = 4'b0111;
            repeat (3) tick(); net_output_spikes = 4'b0110;
            repeat (2) tick(); net_output_spikes = '0;
            repeat (3) tick(); start = 1'b1; load_weights = 1'b1;
            tick(); start = 1'b0; load_weights = 1'b0;
         end
      join
      wait_idle();

      // Neuron 3 held high through a long stalled RUN: count saturates at 31.
      net_output_spikes = 4'b1000;
      do_start(1'b0, 3, 31);
      for (int i = 0; i < NT; i++) sframe(4'b0011, 2);
      wait_idle();
      net_output_spikes = '0;

      // Abort in LOAD right after a handshake: in-flight write lands, nothing else changes.
      do_start(1'b1, 0, 0);
      for (int b = 0; b < 5; b++) wbeat(100 + b);
      abort = 1'b1; w_valid = 1'b1; w_data = 8'hAA;
      tick();
      abort = 1'b0; w_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_prog_en", 32'(synapse_prog_en), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_w_ready", 32'(w_ready), 32'(0));
      repeat (5) tick();
      check("abort_class_kept", 32'(result_class), 32'(3));
      check("abort_count_kept", 32'(result_count), 32'(31));
      check("prog_pulses_abort", 32'(n_prog), 32'(21));

      // A fresh start after abort works normally.
      do_start(1'b0, 1, 4);
      fork
         begin for (int i = 0; i < NT; i++) sframe(4'b0101, 0); end
         begin tick(); net_output_spikes = 4'b0010; repeat (4) tick(); net_output_spikes = '0; end
      join
      wait_idle();

      // Asynchronous reset in the middle of RUN.
      do_start(1'b0, 0, 0);
      net_output_spikes = 4'b1111;
      for (int i = 0; i < 3; i++) sframe(4'b1010, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_s_ready", 32'(s_ready), 32'(0));
      check("mid_rst_net_in", 32'(net_input_spikes), 32'(0));
      check("mid_rst_class", 32'(result_class), 32'(0));
      check("mid_rst_count", 32'(result_count), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      net_output_spikes = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 32'(0));

      repeat (3) tick();
      check("done_pulses", 32'(n_done), 32'(5));
      check("res_queue_empty", 32'(res_q.size()), 32'(0));
      check("wr_queue_empty", 32'(wr_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
